// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared widths, entry record and pointer type for the reorder buffer
package rob_pkg;

  localparam int ROB_DEPTH  = 64;
  localparam int ROB_DISP_W = 2;
  localparam int ROB_CMP_W  = 4;
  localparam int ROB_RET_W  = 2;
  localparam int ROB_PREG_W = 6;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);

  // Head/tail pointer: low ROB_TAG_W bits index the array, the MSB is the wrap bit.
  typedef logic [ROB_TAG_W:0] ptr_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  store;
    logic [ROB_PREG_W-1:0] dest;
    logic [ROB_PREG_W-1:0] old_dest;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// rtl/rob_retire_select.sv - in-order prefix chain choosing which head entries retire
module rob_retire_select
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int RET_W = ROB_RET_W,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0] head_idx_i,
  input  logic [DEPTH-1:0] rdy_vec_i,
  output logic [RET_W-1:0] ret_mask_o,
  output logic [TAG_W:0]   ret_cnt_o
);

  logic chain;

  // Lane j retires only while every entry from head up to head+j is ready; index wraps naturally.
  always_comb begin
    ret_mask_o = '0;
    ret_cnt_o  = '0;
    chain      = 1'b1;
    for (int j = 0; j < RET_W; j++) begin
      chain         = chain & rdy_vec_i[head_idx_i + TAG_W'(j)];
      ret_mask_o[j] = chain;
      if (chain) ret_cnt_o = ret_cnt_o + {{TAG_W{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - multi-lane reorder buffer with tag completion, flush and store-aware retire
module rob_multi
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DISP_W = ROB_DISP_W,
  parameter int CMP_W  = ROB_CMP_W,
  parameter int RET_W  = ROB_RET_W,
  parameter int PREG_W = ROB_PREG_W,
  parameter int DATA_W = ROB_DATA_W,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DISP_W-1:0]        disp_valid,
  input  logic [DISP_W*PREG_W-1:0] disp_dest,
  input  logic [DISP_W*PREG_W-1:0] disp_old_dest,
  input  logic [DISP_W-1:0]        disp_store,
  output logic                     disp_ready,
  output logic [DISP_W*TAG_W-1:0]  disp_tag,
  input  logic [CMP_W-1:0]         cmp_valid,
  input  logic [CMP_W*TAG_W-1:0]   cmp_tag,
  input  logic [CMP_W*DATA_W-1:0]  cmp_data,
  input  logic                     flush,
  output logic [RET_W-1:0]         ret_valid,
  output logic [RET_W*PREG_W-1:0]  ret_dest,
  output logic [RET_W*PREG_W-1:0]  ret_old_dest,
  output logic [RET_W*DATA_W-1:0]  ret_data,
  output logic [RET_W-1:0]         ret_store,
  output logic [TAG_W:0]           count,
  output logic                     empty
);

  rob_entry_t ent_q [DEPTH];

  ptr_t             head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [TAG_W-1:0] head_idx, tail_idx;

  logic [RET_W-1:0]        ret_valid_q, ret_valid_d;
  logic [RET_W-1:0]        ret_store_q, ret_store_d;
  logic [RET_W*PREG_W-1:0] ret_dest_q, ret_dest_d;
  logic [RET_W*PREG_W-1:0] ret_old_dest_q, ret_old_dest_d;
  logic [RET_W*DATA_W-1:0] ret_data_q, ret_data_d;

  logic [DEPTH-1:0] rdy_vec;
  logic [RET_W-1:0] ret_mask;
  logic [TAG_W:0]   ret_cnt;
  logic [TAG_W:0]   free_cnt;
  logic [TAG_W:0]   disp_n;
  logic             disp_fire;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Dispatch admission uses only the registered count; same-cycle retires do not free space.
  assign free_cnt   = (TAG_W+1)'(DEPTH) - count_q;
  assign disp_ready = free_cnt >= (TAG_W+1)'(DISP_W);
  assign disp_fire  = disp_ready && (|disp_valid);

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign ret_valid = ret_valid_q;
  assign ret_store = ret_store_q;
  assign ret_dest  = ret_dest_q;
  assign ret_old_dest = ret_old_dest_q;
  assign ret_data  = ret_data_q;

  // Per-lane tags are tail+lane, and the tail moves by the number of requesting lanes.
  always_comb begin
    disp_n = '0;
    for (int i = 0; i < DISP_W; i++) begin
      disp_tag[i*TAG_W +: TAG_W] = tail_idx + TAG_W'(i);
      if (disp_valid[i]) disp_n = disp_n + {{TAG_W{1'b0}}, 1'b1};
    end
  end

  // An entry can retire once it is both allocated and completed.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = ent_q[i].valid & ent_q[i].done;
    end
  end

  rob_retire_select #(
    .DEPTH (DEPTH),
    .RET_W (RET_W),
    .TAG_W (TAG_W)
  ) u_retire_select (
    .head_idx_i (head_idx),
    .rdy_vec_i  (rdy_vec),
    .ret_mask_o (ret_mask),
    .ret_cnt_o  (ret_cnt)
  );

  // Next pointers, occupancy and retire payload; lanes that do not retire carry zeros.
  always_comb begin
    head_d         = head_q + ret_cnt;
    tail_d         = disp_fire ? (tail_q + disp_n) : tail_q;
    count_d        = count_q + (disp_fire ? disp_n : '0) - ret_cnt;
    ret_valid_d    = ret_mask;
    ret_store_d    = '0;
    ret_dest_d     = '0;
    ret_old_dest_d = '0;
    ret_data_d     = '0;
    for (int j = 0; j < RET_W; j++) begin
      if (ret_mask[j]) begin
        ret_store_d[j]                      = ent_q[head_idx + TAG_W'(j)].store;
        ret_dest_d[j*PREG_W +: PREG_W]      = ent_q[head_idx + TAG_W'(j)].dest;
        ret_old_dest_d[j*PREG_W +: PREG_W]  = ent_q[head_idx + TAG_W'(j)].old_dest;
        ret_data_d[j*DATA_W +: DATA_W]      = ent_q[head_idx + TAG_W'(j)].data;
      end
    end
  end

  // State update: reset and flush wipe everything; otherwise complete, then retire, then allocate.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      ret_valid_q    <= '0;
      ret_store_q    <= '0;
      ret_dest_q     <= '0;
      ret_old_dest_q <= '0;
      ret_data_q     <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      ret_valid_q    <= ret_valid_d;
      ret_store_q    <= ret_store_d;
      ret_dest_q     <= ret_dest_d;
      ret_old_dest_q <= ret_old_dest_d;
      ret_data_q     <= ret_data_d;
      // Ascending lane order lets the highest lane win a same-tag collision.
      for (int k = 0; k < CMP_W; k++) begin
        if (cmp_valid[k] && ent_q[cmp_tag[k*TAG_W +: TAG_W]].valid) begin
          ent_q[cmp_tag[k*TAG_W +: TAG_W]].done <= 1'b1;
          ent_q[cmp_tag[k*TAG_W +: TAG_W]].data <= cmp_data[k*DATA_W +: DATA_W];
        end
      end
      for (int j = 0; j < RET_W; j++) begin
        if (ret_mask[j]) ent_q[head_idx + TAG_W'(j)] <= '0;
      end
      if (disp_fire) begin
        for (int i = 0; i < DISP_W; i++) begin
          if (disp_valid[i]) begin
            ent_q[tail_idx + TAG_W'(i)] <= '{valid:    1'b1,
                                             done:     1'b0,
                                             store:    disp_store[i],
                                             dest:     disp_dest[i*PREG_W +: PREG_W],
                                             old_dest: disp_old_dest[i*PREG_W +: PREG_W],
                                             data:     '0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// tb/tb_rob_multi.sv - directed table-driven bench for rob_multi
module tb_rob_multi;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   disp_valid;
  logic [11:0]  disp_dest;
  logic [11:0]  disp_old_dest;
  logic [1:0]   disp_store;
  logic         disp_ready;
  logic [11:0]  disp_tag;
  logic [3:0]   cmp_valid;
  logic [23:0]  cmp_tag;
  logic [127:0] cmp_data;
  logic         flush;
  logic [1:0]   ret_valid;
  logic [11:0]  ret_dest;
  logic [11:0]  ret_old_dest;
  logic [63:0]  ret_data;
  logic [1:0]   ret_store;
  logic [6:0]   count;
  logic         empty;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0]   cv;
    logic [23:0]  ctag;
    logic [127:0] cdata;
    logic [1:0]   e_rv;
    logic [63:0]  e_rdata;
    logic [1:0]   e_rstore;
    logic [6:0]   e_cnt;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  rob_multi dut (
    .clk           (clk),
    .rst           (rst),
    .disp_valid    (disp_valid),
    .disp_dest     (disp_dest),
    .disp_old_dest (disp_old_dest),
    .disp_store    (disp_store),
    .disp_ready    (disp_ready),
    .disp_tag      (disp_tag),
    .cmp_valid     (cmp_valid),
    .cmp_tag       (cmp_tag),
    .cmp_data      (cmp_data),
    .flush         (flush),
    .ret_valid     (ret_valid),
    .ret_dest      (ret_dest),
    .ret_old_dest  (ret_old_dest),
    .ret_data      (ret_data),
    .ret_store     (ret_store),
    .count         (count),
    .empty         (empty)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = '0;
    disp_store = '0;
    cmp_valid  = '0;
    cmp_tag    = '0;
    cmp_data   = '0;
    flush      = 1'b0;
  endtask

  task automatic cmp1(input int lane, input int tag, input logic [31:0] d);
    cmp_valid[lane]         = 1'b1;
    cmp_tag[lane*6 +: 6]    = 6'(tag);
    cmp_data[lane*32 +: 32] = d;
  endtask

  initial begin
    tbl[0] = '{4'b1011, {6'd2, 6'd0, 6'd40, 6'd2}, {32'd9, 32'd0, 32'hDEAD, 32'd5},
               2'b00, 64'd0, 2'b00, 7'd2};
    tbl[1] = '{4'b0010, {6'd0, 6'd0, 6'd1, 6'd0}, {32'd0, 32'd0, 32'h77, 32'd0},
               2'b00, 64'd0, 2'b00, 7'd2};
    tbl[2] = '{4'b0000, 24'd0, 128'd0,
               2'b11, {32'd9, 32'h77}, 2'b10, 7'd0};
    tbl[3] = '{4'b0100, {6'd0, 6'd40, 6'd0, 6'd0}, {32'd0, 32'd1, 32'd0, 32'd0},
               2'b00, 64'd0, 2'b00, 7'd0};

    rst = 1'b1;
    idle();
    disp_dest = '0;
    disp_old_dest = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_ret_valid", 64'(ret_valid), 64'd0);
    chk("rst_ret_data", ret_data, 64'd0);

    // fill the ROB two per cycle
    for (int c = 0; c < 32; c++) begin
      chk("fill_tag", 64'(disp_tag), 64'({6'(2*c+1), 6'(2*c)}));
      disp_valid    = 2'b11;
      disp_dest     = {6'(2*c+1), 6'(2*c)};
      disp_old_dest = {6'(62-2*c), 6'(63-2*c)};
      step();
    end
    idle();
    chk("full_count", 64'(count), 64'd64);
    chk("full_ready", 64'(disp_ready), 64'd0);
    chk("full_empty", 64'(empty), 64'd0);
    disp_valid = 2'b11;
    step();
    idle();
    chk("full_ignore_count", 64'(count), 64'd64);

    // out-of-order completion: tag 1 first, then the head
    cmp1(0, 1, 32'hA1);
    step();
    idle();
    step();
    chk("ooo_no_retire", 64'(ret_valid), 64'd0);
    chk("ooo_count", 64'(count), 64'd64);
    cmp1(0, 0, 32'hA0);
    disp_valid = 2'b11;
    step();
    idle();
    chk("head_cmp_not_same_cycle", 64'(ret_valid), 64'd0);
    chk("head_cmp_count", 64'(count), 64'd64);
    chk("head_cmp_ready", 64'(disp_ready), 64'd0);
    step();
    chk("pair_ret_valid", 64'(ret_valid), 64'd3);
    chk("pair_ret_data", ret_data, {32'hA1, 32'hA0});
    chk("pair_ret_dest", 64'(ret_dest), 64'({6'd1, 6'd0}));
    chk("pair_ret_old", 64'(ret_old_dest), 64'({6'd62, 6'd63}));
    chk("pair_count", 64'(count), 64'd62);

    // retire two while dispatching one in the same cycle
    cmp1(0, 2, 32'hB2);
    cmp1(1, 3, 32'hB3);
    step();
    idle();
    chk("mix_ready", 64'(disp_ready), 64'd1);
    chk("mix_tag", 64'(disp_tag), 64'({6'd1, 6'd0}));
    disp_valid    = 2'b01;
    disp_dest     = {6'd0, 6'h11};
    disp_old_dest = {6'd0, 6'h22};
    step();
    idle();
    chk("mix_ret_valid", 64'(ret_valid), 64'd3);
    chk("mix_ret_data", ret_data, {32'hB3, 32'hB2});
    chk("mix_count", 64'(count), 64'd61);

    // drain 4..62 so the head sits at 63 with tail at 1
    for (int b = 4; b <= 62; b += 4) begin
      idle();
      for (int k = 0; k < 4; k++) begin
        if (b + k <= 62) cmp1(k, b + k, 32'h100 + 32'(b + k));
      end
      step();
    end
    idle();
    begin
      int w = 0;
      while (count !== 7'd2 && w < 200) begin
        step();
        w++;
      end
    end
    chk("drain_count", 64'(count), 64'd2);
    cmp1(0, 63, 32'hC3F);
    cmp1(1, 0, 32'hC00);
    step();
    idle();
    chk("wrap_no_retire_yet", 64'(ret_valid), 64'd0);
    step();
    chk("wrap_ret_valid", 64'(ret_valid), 64'd3);
    chk("wrap_ret_data", ret_data, {32'hC00, 32'hC3F});
    chk("wrap_ret_dest", 64'(ret_dest), 64'({6'h11, 6'd63}));
    chk("wrap_ret_old", 64'(ret_old_dest), 64'({6'h22, 6'd0}));
    chk("wrap_count", 64'(count), 64'd0);
    chk("wrap_empty", 64'(empty), 64'd1);
    chk("wrap_tail", 64'(disp_tag), 64'({6'd2, 6'd1}));

    // collisions and invalid-tag completions from the table
    disp_valid    = 2'b11;
    disp_dest     = {6'd6, 6'd5};
    disp_old_dest = {6'd8, 6'd7};
    disp_store    = 2'b10;
    step();
    idle();
    chk("tbl_setup_count", 64'(count), 64'd2);
    for (int r = 0; r < 4; r++) begin
      cmp_valid = tbl[r].cv;
      cmp_tag   = tbl[r].ctag;
      cmp_data  = tbl[r].cdata;
      step();
      idle();
      chk($sformatf("tbl%0d_ret_valid", r), 64'(ret_valid), 64'(tbl[r].e_rv));
      chk($sformatf("tbl%0d_ret_data", r), ret_data, tbl[r].e_rdata);
      chk($sformatf("tbl%0d_ret_store", r), 64'(ret_store), 64'(tbl[r].e_rstore));
      chk($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].e_cnt));
    end

    // flush with ten live entries, three of them done including the head
    for (int c = 0; c < 5; c++) begin
      disp_valid    = 2'b11;
      disp_dest     = {6'(c+20), 6'(c+30)};
      disp_old_dest = {6'(c+40), 6'(c+50)};
      step();
    end
    idle();
    chk("pre_flush_count", 64'(count), 64'd10);
    chk("pre_flush_tag", 64'(disp_tag), 64'({6'd14, 6'd13}));
    cmp1(0, 3, 32'h33);
    cmp1(1, 4, 32'h44);
    cmp1(2, 5, 32'h55);
    step();
    idle();
    flush = 1'b1;
    cmp1(0, 6, 32'h66);
    step();
    idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_ret_valid", 64'(ret_valid), 64'd0);
    chk("flush_tag", 64'(disp_tag), 64'({6'd1, 6'd0}));
    cmp1(0, 3, 32'h99);
    step();
    idle();
    step();
    chk("dead_tag_ret_valid", 64'(ret_valid), 64'd0);
    chk("dead_tag_count", 64'(count), 64'd0);

    // store entry retires with ret_store set
    disp_valid    = 2'b01;
    disp_dest     = {6'd0, 6'h2A};
    disp_old_dest = {6'd0, 6'h15};
    disp_store    = 2'b01;
    step();
    idle();
    cmp1(0, 0, 32'h55);
    step();
    idle();
    step();
    chk("store_ret_valid", 64'(ret_valid), 64'd1);
    chk("store_ret_store", 64'(ret_store), 64'd1);
    chk("store_ret_data", ret_data, {32'd0, 32'h55});
    chk("store_ret_dest", 64'(ret_dest), 64'({6'd0, 6'h2A}));
    chk("store_count", 64'(count), 64'd0);

    // reset while two completed entries are about to retire
    disp_valid    = 2'b11;
    disp_dest     = {6'd9, 6'd8};
    disp_old_dest = {6'd3, 6'd2};
    step();
    idle();
    cmp1(0, 1, 32'h1);
    cmp1(1, 2, 32'h2);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ret_valid", 64'(ret_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_tag", 64'(disp_tag), 64'({6'd1, 6'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
